// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with a built-in IF/ID pipeline register.
// Owns the program counter and fetches over a req/ack handshake. It uses a
// one-entry skid buffer to absorb decode stalls. It can drain a request that is
// still outstanding when a redirect arrives.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'd100,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] dinstOut,
    output logic [31:0] dpc,
    output logic        dvalid
);

    // FETCH: request at pc. HOLD: skid buffer occupied, no request.
    // DRAIN: waiting out a request that a redirect made stale.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] dinst_reg, dinst_next;
    logic [31:0] dpc_reg, dpc_next;
    logic        dvalid_reg, dvalid_next;
    // The skid buffer holds a word exactly while the FSM is in HOLD, so no
    // separate occupancy flag is kept.
    logic [31:0] skid_inst_reg, skid_inst_next;
    logic [31:0] skid_pc_reg, skid_pc_next;
    logic [31:0] drain_addr_reg, drain_addr_next;

    logic [31:0] pc_plus4;
    assign pc_plus4 = pc_reg + 32'd4;

    // State register with asynchronous, immediate reset
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg      <= FETCH;
            pc_reg         <= RESET_PC;
            dinst_reg      <= NOP;
            dpc_reg        <= 32'd0;
            dvalid_reg     <= 1'b0;
            skid_inst_reg  <= 32'd0;
            skid_pc_reg    <= 32'd0;
            drain_addr_reg <= 32'd0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            dinst_reg      <= dinst_next;
            dpc_reg        <= dpc_next;
            dvalid_reg     <= dvalid_next;
            skid_inst_reg  <= skid_inst_next;
            skid_pc_reg    <= skid_pc_next;
            drain_addr_reg <= drain_addr_next;
        end
    end

    // Next-state logic: the priority is redirect, then stall, then fetch progress
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        dinst_next      = dinst_reg;
        dpc_next        = dpc_reg;
        dvalid_next     = dvalid_reg;
        skid_inst_next  = skid_inst_reg;
        skid_pc_next    = skid_pc_reg;
        drain_addr_next = drain_addr_reg;

        unique case (state_reg)
            FETCH: begin
                if (redirect) begin
                    // The returning word, if any, belongs to the old path
                    pc_next     = redirect_pc;
                    dvalid_next = 1'b0;
                    dinst_next  = NOP;
                    if (!imem_ack) begin
                        drain_addr_next = pc_reg;
                        state_next      = DRAIN;
                    end
                end else if (imem_ack) begin
                    if (!stall || !dvalid_reg) begin
                        dinst_next  = imem_rdata;
                        dpc_next    = pc_reg;
                        dvalid_next = 1'b1;
                        pc_next     = pc_plus4;
                    end else begin
                        // Decode is full and stalled: park the word
                        skid_inst_next = imem_rdata;
                        skid_pc_next   = pc_reg;
                        pc_next        = pc_plus4;
                        state_next     = HOLD;
                    end
                end else if (!stall) begin
                    // Bubble while memory is busy; dpc keeps its last value
                    dvalid_next = 1'b0;
                    dinst_next  = NOP;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_next     = redirect_pc;
                    dvalid_next = 1'b0;
                    dinst_next  = NOP;
                    state_next  = FETCH;
                end else if (!stall) begin
                    dinst_next  = skid_inst_reg;
                    dpc_next    = skid_pc_reg;
                    dvalid_next = 1'b1;
                    state_next  = FETCH;
                end
            end
            DRAIN: begin
                // IF/ID stays flushed and stall is irrelevant here
                dvalid_next = 1'b0;
                dinst_next  = NOP;
                if (redirect) begin
                    pc_next = redirect_pc;
                end
                if (imem_ack) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Memory request is gated by reset so it drops the instant clrn falls
    always_comb begin
        imem_req  = clrn && (state_reg != HOLD);
        imem_addr = (state_reg == DRAIN) ? drain_addr_reg : pc_reg;
    end

    assign pc       = pc_reg;
    assign dinstOut = dinst_reg;
    assign dpc      = dpc_reg;
    assign dvalid   = dvalid_reg;

endmodule
